// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial add/subtract engine.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_bit.sv
// Combinational 1-bit full-adder slice; no state, zero latency, no flow control.
module addsub_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);

    assign s_o    = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial A+B / A-B, one bit per clock; result valid WIDTH edges after accept, held under out_ready=0.
// Defining SERIAL_ADDSUB_OVF_EN adds the signed-overflow output out_ovf.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
`ifdef SERIAL_ADDSUB_OVF_EN
    localparam logic [CW-1:0] PENULT_BIT = CW'(WIDTH - 2);
`endif

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             sum_d;
    logic             cout_d;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic             c_msb_q;
`endif

    addsub_bit u_slice (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .cin_i  (carry_q),
        .s_o    (sum_d),
        .cout_o (cout_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_ADDSUB_OVF_EN
            c_msb_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract runs as A + ~B + 1: invert B, seed the carry with 1.
                        a_q     <= in_a;
                        b_q     <= (in_op == OP_SUB) ? ~in_b : in_b;
                        carry_q <= (in_op == OP_SUB);
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    res_q   <= {sum_d, res_q[WIDTH-1:1]};
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= cout_d;
                    cnt_q   <= cnt_q + 1'b1;
`ifdef SERIAL_ADDSUB_OVF_EN
                    if (cnt_q == PENULT_BIT) begin
                        c_msb_q <= cout_d;
                    end
`endif
                    if (cnt_q == LAST_BIT) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_result = res_q;
    assign out_carry  = carry_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    assign out_ovf    = (state_q == DONE) ? (c_msb_q ^ carry_q) : 1'b0;
`endif

endmodule
